// File: rtl/fir_stream_pkg.sv
// Shared definitions for the 4-tap streaming FIR coefficient path.
// Contents:
//   FL_VALID, FL_EOP  : bit indices into a stream's mflags vector
//   FL_STALL          : bit index into a stream's sflags vector
//   FIR_MF_CONST      : mflags driven on the coefficient stream once a bank is live
//   FIR_MF_IDLE       : mflags driven before the first commit (holds the FIR stalled)
//   state_t           : frame-tracking state of the coefficient bank controller
package fir_stream_pkg;

  localparam int FL_VALID = 0;
  localparam int FL_EOP   = 2;
  localparam int FL_STALL = 0;

  localparam logic [3:0] FIR_MF_CONST = 4'b0111;
  localparam logic [3:0] FIR_MF_IDLE  = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // no frame in progress
    ST_IN_FRAME = 2'd1,  // inside a frame, no commit waiting
    ST_PENDING  = 2'd2   // inside a frame, commit waiting for its last beat
  } state_t;

endpackage

// File: rtl/fir_coef_ctrl.sv
// Coefficient bank controller for the 4-tap streaming FIR.
// A shadow bank is loaded through the cfg_* port; cfg_commit copies it into
// the active bank (B0..B3), but only at a frame boundary of the multiplier
// input stream so that no frame is filtered with a mix of old and new taps.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   cfg_wr/addr/wdata : shadow tap write
//   cfg_commit        : request shadow -> active swap (pulse)
//   cfg_busy          : a commit is waiting for the end of the current frame
//   cfg_err           : one-cycle pulse, a write or commit was rejected
//   mon_mflags/sflags : monitor of the multiplier-input stream flags
//   B0..B3            : active coefficients
//   coef_mflags       : coefficient-stream mflags (idle until the first swap)
//   swap_cnt          : completed swaps, modulo 256
//   dbg_state         : current controller state (state_t encoding)
//
// Handshake: a beat is accepted in a cycle when its VALID flag is set and the
// stream is not stalled (sflags STALL clear); only accepted beats advance the
// frame tracking, and an accepted beat carrying EOP closes its frame.
module fir_coef_ctrl
  import fir_stream_pkg::*;
#(
  parameter int W    = 32,
  parameter int NTAP = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_wr,
  input  logic [1:0]   cfg_addr,
  input  logic [W-1:0] cfg_wdata,
  input  logic         cfg_commit,
  output logic         cfg_busy,
  output logic         cfg_err,
  input  logic [3:0]   mon_mflags,
  input  logic [1:0]   mon_sflags,
  output logic [W-1:0] B0,
  output logic [W-1:0] B1,
  output logic [W-1:0] B2,
  output logic [W-1:0] B3,
  output logic [3:0]   coef_mflags,
  output logic [7:0]   swap_cnt,
  output logic [1:0]   dbg_state
);

  state_t       state_q, state_d;
  logic [W-1:0] shadow_q [NTAP];
  logic [W-1:0] shadow_d [NTAP];
  logic [W-1:0] active_q [NTAP];
  logic         acc, last;
  logic         do_swap, err_d, wr_ok;
  logic         busy_q, err_q;
  logic [3:0]   mflags_q;
  logic [7:0]   cnt_q;

  // Remaining flag bits carry nothing this block cares about.
  logic unused_flags;
  assign unused_flags = ^{mon_mflags[3], mon_mflags[1], mon_sflags[1]};

  assign acc  = mon_mflags[FL_VALID] & ~mon_sflags[FL_STALL];
  assign last = acc & mon_mflags[FL_EOP];

  always_comb begin
    state_d = state_q;
    do_swap = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_commit) begin
          // Only a beat that opens a multi-beat frame defers the swap.
          if (acc && !last) state_d = ST_PENDING;
          else              do_swap = 1'b1;
        end else if (acc && !last) begin
          state_d = ST_IN_FRAME;
        end
      end
      ST_IN_FRAME: begin
        if (last) begin
          state_d = ST_IDLE;
          do_swap = cfg_commit;
        end else if (cfg_commit) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (last) begin
          do_swap = 1'b1;
          state_d = ST_IDLE;
        end
        // Any write or extra commit would change the bank already promised.
        err_d = cfg_wr | cfg_commit;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A write in the commit cycle must be part of the swapped bank, so the swap
  // copies the post-write shadow view rather than the registered one.
  assign wr_ok = cfg_wr && (state_q != ST_PENDING);

  always_comb begin
    for (int i = 0; i < NTAP; i++) begin
      shadow_d[i] = (wr_ok && (int'(cfg_addr) == i)) ? cfg_wdata : shadow_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      mflags_q <= FIR_MF_IDLE;
      cnt_q    <= 8'd0;
      for (int i = 0; i < NTAP; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_PENDING);
      err_q   <= err_d;
      for (int i = 0; i < NTAP; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      if (do_swap) begin
        for (int i = 0; i < NTAP; i++) begin
          active_q[i] <= shadow_d[i];
        end
        mflags_q <= FIR_MF_CONST;
        cnt_q    <= cnt_q + 8'd1;
      end
    end
  end

  assign B0          = active_q[0];
  assign B1          = active_q[1];
  assign B2          = active_q[2];
  assign B3          = active_q[3];
  assign cfg_busy    = busy_q;
  assign cfg_err     = err_q;
  assign coef_mflags = mflags_q;
  assign swap_cnt    = cnt_q;
  assign dbg_state   = state_q;

endmodule
